// File: rtl/viterbi_frame_feeder.sv
// Ping-pong score buffer feeding the Viterbi word-spotting core, one tagged result per frame.
// Optional core watchdog enabled by defining VITERBI_TIMEOUT_EN.
module viterbi_frame_feeder #(
    parameter int STATE   = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        v_start,
    output logic        v_write,
    output logic [15:0] v_index,
    output logic [31:0] v_x,
    input  logic        v_busy,
    input  logic        v_dv,
    input  logic        v_result,
    output logic        r_valid,
    output logic [15:0] r_frame,
    output logic        r_result,
    output logic [1:0]  frames_pend,
    output logic        err_len,
    output logic        err_timeout
);
    localparam int PW = (STATE > 1) ? $clog2(STATE) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, TRIG, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, rd_bank_q;
    logic [PW-1:0]   wr_ptr_q, k_q, k_d;
    logic [15:0]     frame_q, r_frame_q;
    logic            r_result_q, err_len_q, run_q;
    logic [31:0]     bank_q [2][STATE];

    logic accept, last_slot, fill, bad_len, tmo_fire, release_bank;

    assign accept    = s_valid & s_ready;
    assign last_slot = (wr_ptr_q == PW'(STATE - 1));
    assign fill      = accept & s_last & last_slot;
    // Early s_last or a missing s_last both drop the frame.
    assign bad_len   = accept & (s_last ^ last_slot);

`ifdef VITERBI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_tmo_q;

    // A result arriving on the expiry cycle wins over the timeout.
    assign tmo_fire = ((state_q == TRIG) || (state_q == RUN && !v_dv)) &&
                      (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            if (state_q == TRIG || state_q == RUN) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                                   tmo_cnt_q <= '0;
            if (tmo_fire) err_tmo_q <= 1'b1;
        end
    end
    assign err_timeout = err_tmo_q;
`else
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign release_bank = (state_q == DONE) | tmo_fire;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        v_start = 1'b0;
        v_write = 1'b0;
        v_index = '0;
        v_x     = '0;
        r_valid = 1'b0;
        case (state_q)
            IDLE: if (full_q[rd_bank_q]) begin
                state_d = LOAD;
                k_d     = '0;
            end
            LOAD: begin
                v_start = 1'b1;
                v_write = 1'b1;
                v_index = 16'(k_q);
                v_x     = bank_q[rd_bank_q][k_q];
                if (k_q == PW'(STATE - 1)) state_d = TRIG;
                else                       k_d = k_q + 1'b1;
            end
            TRIG: begin
                v_start = 1'b1;
                if (v_busy) state_d = RUN;
            end
            RUN: begin
                v_start = 1'b1;
                if (v_dv) state_d = DONE;
            end
            DONE: begin
                r_valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tmo_fire) state_d = IDLE;
    end

    // Fill and release never target the same bank: a full bank blocks input.
    always_comb begin
        full_d = full_q;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
        if (fill)         full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            frame_q    <= '0;
            r_frame_q  <= '0;
            r_result_q <= 1'b0;
            err_len_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            k_q     <= k_d;
            full_q  <= full_d;
            if (accept) begin
                if (s_last || last_slot) wr_ptr_q <= '0;
                else                     wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fill)    wr_bank_q <= ~wr_bank_q;
            if (bad_len) err_len_q <= 1'b1;
            if (state_q == RUN && v_dv) begin
                r_result_q <= v_result;
                r_frame_q  <= frame_q;
                frame_q    <= frame_q + 1'b1;
            end else if (tmo_fire) begin
                frame_q    <= frame_q + 1'b1;
            end
            if (release_bank) rd_bank_q <= ~rd_bank_q;
        end
    end

    // Score storage carries no reset; the full flags alone say what is valid.
    always_ff @(posedge clk) begin
        if (accept) bank_q[wr_bank_q][wr_ptr_q] <= s_data;
    end

    assign s_ready     = run_q & ~full_q[wr_bank_q];
    assign frames_pend = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign r_frame     = r_frame_q;
    assign r_result    = r_result_q;
    assign err_len     = err_len_q;
endmodule
